// File: rtl/eei_dispatch_pkg.sv
// rtl/eei_dispatch_pkg.sv - shared types and encodings for the EEI dispatcher
package eei_dispatch_pkg;

    localparam int EEI_RS_MAX = 4;
    localparam int EEI_RD_MAX = 4;

    localparam logic [1:0] EEI_RD_NONE   = 2'd0;
    localparam logic [1:0] EEI_RD_SINGLE = 2'd1;
    localparam logic [1:0] EEI_RD_BATCH  = 2'd2;
    localparam logic [1:0] EEI_RD_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        EEI_ST_IDLE = 2'd0,
        EEI_ST_BUSY = 2'd1,
        EEI_ST_RESP = 2'd2
    } eei_disp_state_e;

endpackage

// File: rtl/eei_dispatch_if.sv
// rtl/eei_dispatch_if.sv - core-side EEI request/response bundle
interface eei_dispatch_if
    import eei_dispatch_pkg::*;
#(
    parameter int RS_MAX = EEI_RS_MAX,
    parameter int RD_MAX = EEI_RD_MAX
) ();

    logic                   eei_req;
    logic                   eei_ext;
    logic [2:0]             eei_funct3;
    logic [6:0]             eei_funct7;
    logic [4:0]             eei_batch_start;
    logic [4:0]             eei_batch_len;
    logic [RS_MAX*32-1:0]   eei_rs_val;
    logic                   eei_ack;
    logic                   eei_error;
    logic [1:0]             eei_rd_op;
    logic [4:0]             eei_rd_len;
    logic [RD_MAX*32-1:0]   eei_rd_val;

    modport master (
        output eei_req, eei_ext, eei_funct3, eei_funct7,
               eei_batch_start, eei_batch_len, eei_rs_val,
        input  eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val
    );

    modport slave (
        input  eei_req, eei_ext, eei_funct3, eei_funct7,
               eei_batch_start, eei_batch_len, eei_rs_val,
        output eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val
    );

endinterface

// File: rtl/eei_dispatch_unit_decode.sv
// rtl/eei_dispatch_unit_decode.sv - ext/funct3 match to lowest-index unit
module eei_unit_decode #(
    parameter int                     NUM_UNITS   = 4,
    parameter logic [NUM_UNITS-1:0]   UNIT_EXT    = '0,
    parameter logic [NUM_UNITS*3-1:0] UNIT_FUNCT3 = '0,
    parameter int                     SEL_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 ext,
    input  logic [2:0]           funct3,
    output logic                 hit,
    output logic [NUM_UNITS-1:0] onehot,
    output logic [SEL_W-1:0]     sel
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        sel    = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (UNIT_EXT[k] == ext && UNIT_FUNCT3[k*3 +: 3] == funct3) begin
                hit       = 1'b1;
                onehot    = '0;
                onehot[k] = 1'b1;
                sel       = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/eei_dispatch.sv
// rtl/eei_dispatch.sv - sequential EEI dispatcher to NUM_UNITS execution units
module eei_dispatch
    import eei_dispatch_pkg::*;
#(
    parameter int                     NUM_UNITS   = 4,
    parameter logic [NUM_UNITS-1:0]   UNIT_EXT    = '0,
    parameter logic [NUM_UNITS*3-1:0] UNIT_FUNCT3 = '0,
    parameter int                     RS_MAX      = EEI_RS_MAX,
    parameter int                     RD_MAX      = EEI_RD_MAX,
    parameter int                     TIMEOUT     = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    eei_dispatch_if.slave                   eei,
    output logic [NUM_UNITS-1:0]            u_req,
    output logic [6:0]                      u_funct7,
    output logic [4:0]                      u_batch_start,
    output logic [4:0]                      u_batch_len,
    output logic [RS_MAX*32-1:0]            u_rs_val,
    input  logic [NUM_UNITS-1:0]            u_ack,
    input  logic [NUM_UNITS-1:0]            u_error,
    input  logic [NUM_UNITS*2-1:0]          u_rd_op,
    input  logic [NUM_UNITS*5-1:0]          u_rd_len,
    input  logic [NUM_UNITS*RD_MAX*32-1:0]  u_rd_val
);

    localparam int              SEL_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [5:0]      RD_LIMIT = 6'(RD_MAX);

    localparam logic [1:0] ST_IDLE = EEI_ST_IDLE;
    localparam logic [1:0] ST_BUSY = EEI_ST_BUSY;
    localparam logic [1:0] ST_RESP = EEI_ST_RESP;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] cnt;

    logic                 dec_hit;
    logic [NUM_UNITS-1:0] dec_onehot;
    logic [SEL_W-1:0]     dec_sel;

    eei_unit_decode #(
        .NUM_UNITS   (NUM_UNITS),
        .UNIT_EXT    (UNIT_EXT),
        .UNIT_FUNCT3 (UNIT_FUNCT3),
        .SEL_W       (SEL_W)
    ) u_decode (
        .ext    (eei.eei_ext),
        .funct3 (eei.eei_funct3),
        .hit    (dec_hit),
        .onehot (dec_onehot),
        .sel    (dec_sel)
    );

    logic [1:0]           op_arr  [NUM_UNITS];
    logic [4:0]           len_arr [NUM_UNITS];
    logic [RD_MAX*32-1:0] val_arr [NUM_UNITS];

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unpack
        assign op_arr[k]  = u_rd_op[k*2 +: 2];
        assign len_arr[k] = u_rd_len[k*5 +: 5];
        assign val_arr[k] = u_rd_val[k*RD_MAX*32 +: RD_MAX*32];
    end

    logic                 sel_ack;
    logic                 sel_err;
    logic [1:0]           sel_op;
    logic [4:0]           sel_len;
    logic [RD_MAX*32-1:0] sel_val;

    assign sel_ack = u_ack[sel];
    assign sel_err = u_error[sel];
    assign sel_op  = op_arr[sel];
    assign sel_len = len_arr[sel];
    assign sel_val = val_arr[sel];

    logic       bad_rsp;
    logic       rsp_err;
    logic [1:0] rsp_op;
    logic [4:0] rsp_len;

    // Sanitise the selected unit's response: reserved op or oversize batch becomes an error.
    always_comb begin
        bad_rsp = (sel_op == EEI_RD_RSVD) ||
                  (sel_op == EEI_RD_BATCH && {1'b0, sel_len} > RD_LIMIT);
        rsp_err = sel_err | bad_rsp;
        rsp_op  = bad_rsp ? EEI_RD_NONE : sel_op;
        rsp_len = (rsp_op == EEI_RD_BATCH) ? sel_len : 5'd0;
    end

    // Dispatch FSM: decode in IDLE, hold the unit request in BUSY, strobe the response in RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= ST_IDLE;
            sel             <= '0;
            cnt             <= '0;
            u_req           <= '0;
            u_funct7        <= '0;
            u_batch_start   <= '0;
            u_batch_len     <= '0;
            u_rs_val        <= '0;
            eei.eei_ack     <= 1'b0;
            eei.eei_error   <= 1'b0;
            eei.eei_rd_op   <= EEI_RD_NONE;
            eei.eei_rd_len  <= '0;
            eei.eei_rd_val  <= '0;
        end else begin
            eei.eei_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (eei.eei_req) begin
                        if (dec_hit) begin
                            u_req         <= dec_onehot;
                            u_funct7      <= eei.eei_funct7;
                            u_batch_start <= eei.eei_batch_start;
                            u_batch_len   <= eei.eei_batch_len;
                            u_rs_val      <= eei.eei_rs_val;
                            sel           <= dec_sel;
                            cnt           <= '0;
                            state         <= ST_BUSY;
                        end else begin
                            eei.eei_ack    <= 1'b1;
                            eei.eei_error  <= 1'b1;
                            eei.eei_rd_op  <= EEI_RD_NONE;
                            eei.eei_rd_len <= '0;
                            eei.eei_rd_val <= '0;
                            state          <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!eei.eei_req) begin
                        // Core flushed the instruction: abandon silently.
                        u_req <= '0;
                        state <= ST_IDLE;
                    end else if (sel_ack) begin
                        u_req          <= '0;
                        eei.eei_ack    <= 1'b1;
                        eei.eei_error  <= rsp_err;
                        eei.eei_rd_op  <= rsp_op;
                        eei.eei_rd_len <= rsp_len;
                        eei.eei_rd_val <= sel_val;
                        state          <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        u_req          <= '0;
                        eei.eei_ack    <= 1'b1;
                        eei.eei_error  <= 1'b1;
                        eei.eei_rd_op  <= EEI_RD_NONE;
                        eei.eei_rd_len <= '0;
                        eei.eei_rd_val <= '0;
                        state          <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eei_dispatch.sv
// tb/tb_eei_dispatch.sv - directed self-checking bench for eei_dispatch
module tb_eei_dispatch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   u_req;
    logic [6:0]   u_funct7;
    logic [4:0]   u_batch_start;
    logic [4:0]   u_batch_len;
    logic [127:0] u_rs_val;
    logic [3:0]   u_ack;
    logic [3:0]   u_error;
    logic [7:0]   u_rd_op;
    logic [19:0]  u_rd_len;
    logic [511:0] u_rd_val;

    eei_dispatch_if #(.RS_MAX(4), .RD_MAX(4)) eei ();

    eei_dispatch #(
        .NUM_UNITS   (4),
        .UNIT_EXT    (4'b0110),
        .UNIT_FUNCT3 ({3'd2, 3'd0, 3'd0, 3'd0}),
        .RS_MAX      (4),
        .RD_MAX      (4),
        .TIMEOUT     (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .eei           (eei),
        .u_req         (u_req),
        .u_funct7      (u_funct7),
        .u_batch_start (u_batch_start),
        .u_batch_len   (u_batch_len),
        .u_rs_val      (u_rs_val),
        .u_ack         (u_ack),
        .u_error       (u_error),
        .u_rd_op       (u_rd_op),
        .u_rd_len      (u_rd_len),
        .u_rd_val      (u_rd_val)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int           ack_at;
    int           ureq_cycles;
    logic [3:0]   ureq_seen;
    logic         o_err;
    logic [1:0]   o_op;
    logic [4:0]   o_len;
    logic [127:0] o_val;
    logic [6:0]   o_f7;
    logic [31:0]  o_rs0;
    int           n_ack;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int k, input logic err, input logic [1:0] op,
                            input logic [4:0] len, input logic [31:0] base);
        u_error[k]          = err;
        u_rd_op[k*2 +: 2]   = op;
        u_rd_len[k*5 +: 5]  = len;
        for (int i = 0; i < 4; i++)
            u_rd_val[(k*4+i)*32 +: 32] = base + 32'(i);
    endtask

    // Issue one request at cycle 0; unit 'unit' acks during cycle ack_cyc (-1 = never).
    task automatic txn(input logic ext, input logic [2:0] f3, input int unit,
                       input int ack_cyc, input logic [3:0] noise);
        eei.eei_req         = 1'b1;
        eei.eei_ext         = ext;
        eei.eei_funct3      = f3;
        eei.eei_funct7      = 7'h2A;
        eei.eei_batch_start = 5'd3;
        eei.eei_batch_len   = 5'd2;
        eei.eei_rs_val      = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        ack_at      = -1;
        ureq_cycles = 0;
        ureq_seen   = '0;
        o_f7        = '0;
        o_rs0       = '0;
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            u_ack = noise;
            if (c - 1 == ack_cyc) u_ack[unit] = 1'b1;
            tick();
            if (u_req != 4'd0) begin
                if (ureq_cycles == 0) begin
                    o_f7  = u_funct7;
                    o_rs0 = u_rs_val[31:0];
                end
                ureq_cycles++;
                ureq_seen |= u_req;
            end
            if (eei.eei_ack) begin
                ack_at = c;
                o_err  = eei.eei_error;
                o_op   = eei.eei_rd_op;
                o_len  = eei.eei_rd_len;
                o_val  = eei.eei_rd_val;
            end
        end
        u_ack       = '0;
        eei.eei_req = 1'b0;
        tick();
    endtask

    initial begin
        rst_n               = 1'b0;
        eei.eei_req         = 1'b0;
        eei.eei_ext         = 1'b0;
        eei.eei_funct3      = '0;
        eei.eei_funct7      = '0;
        eei.eei_batch_start = '0;
        eei.eei_batch_len   = '0;
        eei.eei_rs_val      = '0;
        u_ack    = '0;
        u_error  = '0;
        u_rd_op  = '0;
        u_rd_len = '0;
        u_rd_val = '0;
        repeat (3) tick();
        check_eq("rst_ack",    64'(eei.eei_ack), 64'd0);
        check_eq("rst_ureq",   64'(u_req), 64'd0);
        check_eq("rst_rdop",   64'(eei.eei_rd_op), 64'd0);
        check_eq("rst_rdval",  64'(eei.eei_rd_val[63:0]), 64'd0);
        check_eq("rst_funct7", 64'(u_funct7), 64'd0);
        rst_n = 1'b1;
        tick();

        // unit 0 acks in first BUSY cycle
        set_unit(0, 1'b0, 2'd1, 5'd7, 32'hDEADBEEF);
        txn(1'b0, 3'd0, 0, 1, 4'b0000);
        check_eq("u0_ack_at", 64'(ack_at), 64'd2);
        check_eq("u0_ureq",   64'(ureq_seen), 64'h1);
        check_eq("u0_ureqn",  64'(ureq_cycles), 64'd1);
        check_eq("u0_err",    64'(o_err), 64'd0);
        check_eq("u0_op",     64'(o_op), 64'd1);
        check_eq("u0_len",    64'(o_len), 64'd0);
        check_eq("u0_val0",   64'(o_val[31:0]), 64'hDEADBEEF);
        check_eq("u0_f7",     64'(o_f7), 64'h2A);
        check_eq("u0_rs0",    64'(o_rs0), 64'h1111_0000);
        check_eq("u0_post",   64'(eei.eei_ack), 64'd0);

        // unit 1 acks in 6th BUSY cycle, others ack noisily and are ignored
        set_unit(1, 1'b0, 2'd2, 5'd3, 32'h1000_0000);
        txn(1'b1, 3'd0, 1, 6, 4'b0101);
        check_eq("u1_ack_at", 64'(ack_at), 64'd7);
        check_eq("u1_ureq",   64'(ureq_seen), 64'h2);
        check_eq("u1_ureqn",  64'(ureq_cycles), 64'd6);
        check_eq("u1_err",    64'(o_err), 64'd0);
        check_eq("u1_op",     64'(o_op), 64'd2);
        check_eq("u1_len",    64'(o_len), 64'd3);
        check_eq("u1_val",    64'(o_val[95:0]), {32'h1000_0001, 32'h1000_0000});
        check_eq("u1_val2",   64'(o_val[95:64]), 64'h1000_0002);

        // batch length beyond RD_MAX
        set_unit(1, 1'b0, 2'd2, 5'd5, 32'h2000_0000);
        txn(1'b1, 3'd0, 1, 1, 4'b0000);
        check_eq("big_ack_at", 64'(ack_at), 64'd2);
        check_eq("big_err",    64'(o_err), 64'd1);
        check_eq("big_op",     64'(o_op), 64'd0);
        check_eq("big_len",    64'(o_len), 64'd0);

        // reserved rd_op from unit 3
        set_unit(3, 1'b0, 2'd3, 5'd1, 32'h3000_0000);
        txn(1'b0, 3'd2, 3, 1, 4'b0000);
        check_eq("rsv_ureq", 64'(ureq_seen), 64'h8);
        check_eq("rsv_err",  64'(o_err), 64'd1);
        check_eq("rsv_op",   64'(o_op), 64'd0);

        // unmapped opcode
        txn(1'b0, 3'd7, 0, -1, 4'b0000);
        check_eq("miss_ack_at", 64'(ack_at), 64'd1);
        check_eq("miss_ureq",   64'(ureq_seen), 64'd0);
        check_eq("miss_err",    64'(o_err), 64'd1);
        check_eq("miss_op",     64'(o_op), 64'd0);
        check_eq("miss_val",    64'(o_val[63:0]), 64'd0);

        // unit never acks
        set_unit(0, 1'b0, 2'd1, 5'd0, 32'hAAAA_0000);
        txn(1'b0, 3'd0, 0, -1, 4'b0000);
        check_eq("to_ack_at", 64'(ack_at), 64'd17);
        check_eq("to_ureqn",  64'(ureq_cycles), 64'd16);
        check_eq("to_err",    64'(o_err), 64'd1);
        check_eq("to_op",     64'(o_op), 64'd0);
        u_ack = 4'hF;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (eei.eei_ack || u_req != 4'd0) n_ack++;
        end
        u_ack = '0;
        check_eq("late_ack", 64'(n_ack), 64'd0);

        // ack in final BUSY cycle beats timeout; unit error passes through
        set_unit(0, 1'b1, 2'd1, 5'd0, 32'hCAFE_0000);
        txn(1'b0, 3'd0, 0, 16, 4'b0000);
        check_eq("last_ack_at", 64'(ack_at), 64'd17);
        check_eq("last_err",    64'(o_err), 64'd1);
        check_eq("last_op",     64'(o_op), 64'd1);
        check_eq("last_val0",   64'(o_val[31:0]), 64'hCAFE_0000);

        // flush in 3rd BUSY cycle
        eei.eei_req    = 1'b1;
        eei.eei_ext    = 1'b0;
        eei.eei_funct3 = 3'd0;
        repeat (3) tick();
        check_eq("fl_ureq_busy", 64'(u_req), 64'h1);
        eei.eei_req = 1'b0;
        tick();
        check_eq("fl_ureq", 64'(u_req), 64'd0);
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            if (eei.eei_ack) n_ack++;
            tick();
        end
        check_eq("fl_noack", 64'(n_ack), 64'd0);
        set_unit(0, 1'b0, 2'd1, 5'd0, 32'h5A5A_0000);
        txn(1'b0, 3'd0, 0, 2, 4'b0000);
        check_eq("fl_next_at",  64'(ack_at), 64'd3);
        check_eq("fl_next_err", 64'(o_err), 64'd0);
        check_eq("fl_next_val", 64'(o_val[31:0]), 64'h5A5A_0000);

        // reset mid-BUSY on unit 1 (shared with unit 2)
        eei.eei_req    = 1'b1;
        eei.eei_ext    = 1'b1;
        eei.eei_funct3 = 3'd0;
        eei.eei_funct7 = 7'h15;
        repeat (2) tick();
        check_eq("rb_ureq", 64'(u_req), 64'h2);
        rst_n = 1'b0;
        tick();
        check_eq("rb_ureq0",  64'(u_req), 64'd0);
        check_eq("rb_ack",    64'(eei.eei_ack), 64'd0);
        check_eq("rb_funct7", 64'(u_funct7), 64'd0);
        check_eq("rb_rs",     64'(u_rs_val[63:0]), 64'd0);
        check_eq("rb_rdval",  64'(eei.eei_rd_val[63:0]), 64'd0);
        check_eq("rb_err",    64'(eei.eei_error), 64'd0);
        rst_n       = 1'b1;
        eei.eei_req = 1'b0;
        repeat (2) tick();
        check_eq("rb_idle", 64'({eei.eei_ack, u_req}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
